conv2_xnor_core: RTL and testbench



---
 rtl/conv_pkg.sv | 44 ++++
 rtl/conv2_xnor_core_xnor_popcount72.sv | 62 ++++++
 rtl/conv2_xnor_core.sv | 170 +++++++++++++++++
 tb/tb_conv2_xnor_core.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : conv_pkg
// Description : Shared constants, FSM encoding and popcount helpers for the
//               conv2 binary (XNOR-popcount) compute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int WIN_BITS    = 72;   // 8 channels x 3x3 taps
    localparam int POP_W       = 7;    // holds 0..72
    localparam int GRP         = 8;    // bits per partial popcount group
    localparam int NGRP        = 9;    // WIN_BITS / GRP
    localparam int CNT_W       = 4;    // holds 0..8
    localparam int CONV2_OUT_W = 11;
    localparam int CONV2_OUT_H = 11;
    localparam int CONV2_PIX   = CONV2_OUT_W * CONV2_OUT_H;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] popcount8(input logic [GRP-1:0] b);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < GRP; i++) begin
            n = n + CNT_W'(b[i]);
        end
        return n;
    endfunction

    // Nine groups of at most 8 sum to at most 72, so POP_W bits never overflow.
    function automatic logic [POP_W-1:0] sum_groups(input logic [NGRP*CNT_W-1:0] g);
        logic [POP_W-1:0] s;
        s = '0;
        for (int i = 0; i < NGRP; i++) begin
            s = s + POP_W'(g[i*CNT_W +: CNT_W]);
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv2_xnor_core_xnor_popcount72.sv
`default_nettype none
// ============================================================================
// Module      : xnor_popcount72
// Description : Two registered stages for one output channel: XNOR of the
//               window against the channel weight, then nine 8-bit group
//               popcounts. Carries its own valid bit alongside the data.
// Ports       : clk, rst (async, active-high), clear (drops in-flight data),
//               valid_in/window/weight in, grp_cnt/valid_out out.
// Revision    : 1.0 - initial release
// ============================================================================
module xnor_popcount72
    import conv_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     valid_in,
    input  logic [WIN_BITS-1:0]      window,
    input  logic [WIN_BITS-1:0]      weight,
    output logic [NGRP*CNT_W-1:0]    grp_cnt,
    output logic                     valid_out
);

    logic [WIN_BITS-1:0]   xnor_bits;
    logic                  s1_valid;
    logic [NGRP*CNT_W-1:0] grp_next;

    // Stage 1: bitwise agreement between window and weight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xnor_bits <= '0;
            s1_valid  <= 1'b0;
        end else begin
            s1_valid <= valid_in && !clear;
            if (valid_in) begin
                xnor_bits <= ~(window ^ weight);
            end
        end
    end

    always_comb begin
        grp_next = '0;
        for (int g = 0; g < NGRP; g++) begin
            grp_next[g*CNT_W +: CNT_W] = popcount8(xnor_bits[g*GRP +: GRP]);
        end
    end

    // Stage 2: partial popcounts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_cnt   <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= s1_valid && !clear;
            if (s1_valid) begin
                grp_cnt <= grp_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv2_xnor_core.sv
`default_nettype none
// ============================================================================
// Module      : conv2_xnor_core
// Description : Binary conv2 compute stage. Weights/thresholds are loaded
//               serially (LOAD), then each valid 72-bit window produces one
//               OUT_CH-bit activation vector three cycles later (RUN).
// Ports       : clk, rst (async, active-high)
//               valid_in, pixel_windows      - window stream
//               w_valid, w_data, w_thresh    - serial weight load
//               w_clear                      - drop weights, back to LOAD
//               weights_ready, pixel_out, valid_out, frame_done, drop_err
// Revision    : 1.0 - initial release
// ============================================================================
module conv2_xnor_core #(
    parameter int WIN_BITS = conv_pkg::WIN_BITS,
    parameter int OUT_CH   = 16,
    parameter int OUT_W    = conv_pkg::CONV2_OUT_W,
    parameter int OUT_H    = conv_pkg::CONV2_OUT_H
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [WIN_BITS-1:0]        pixel_windows,
    input  logic                       w_valid,
    input  logic [WIN_BITS-1:0]        w_data,
    input  logic [conv_pkg::POP_W-1:0] w_thresh,
    input  logic                       w_clear,
    output logic                       weights_ready,
    output logic [OUT_CH-1:0]          pixel_out,
    output logic                       valid_out,
    output logic                       frame_done,
    output logic                       drop_err
);

    import conv_pkg::*;

    localparam int IDX_W    = $clog2(OUT_CH);
    localparam int PIX_W    = $clog2(OUT_W * OUT_H);
    localparam int PIX_LAST = OUT_W * OUT_H - 1;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       load_idx, load_idx_nxt;
    logic                   load_we;
    logic [WIN_BITS-1:0]    weight [OUT_CH];
    logic [POP_W-1:0]       thresh [OUT_CH];
    logic                   accept;
    logic [NGRP*CNT_W-1:0]  grp_cnt [OUT_CH];
    logic [OUT_CH-1:0]      s2_valid;
    logic                   s2_ok;
    logic [OUT_CH-1:0]      pix_next;
    logic [PIX_W-1:0]       pix_cnt;

    // ------------------------------------------------------------------
    // Load / run FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_LOAD;
            load_idx <= '0;
        end else begin
            state    <= state_nxt;
            load_idx <= load_idx_nxt;
        end
    end

    // w_clear wins over everything, so a coincident weight write is dropped.
    always_comb begin
        state_nxt    = state;
        load_idx_nxt = load_idx;
        load_we      = 1'b0;
        if (w_clear) begin
            state_nxt    = ST_LOAD;
            load_idx_nxt = '0;
        end else if (state == ST_LOAD && w_valid) begin
            load_we = 1'b1;
            if (load_idx == IDX_W'(OUT_CH - 1)) begin
                state_nxt    = ST_RUN;
                load_idx_nxt = '0;
            end else begin
                load_idx_nxt = load_idx + 1'b1;
            end
        end
    end

    assign weights_ready = (state == ST_RUN);

    // Weight contents survive w_clear; they are simply overwritten by reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OUT_CH; i++) begin
                weight[i] <= '0;
                thresh[i] <= '0;
            end
        end else if (load_we) begin
            weight[load_idx] <= w_data;
            thresh[load_idx] <= w_thresh;
        end
    end

    assign accept = valid_in && (state == ST_RUN) && !w_clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_err <= 1'b0;
        end else if (w_clear) begin
            drop_err <= 1'b0;
        end else if (valid_in && state != ST_RUN) begin
            drop_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel XNOR + group popcount (stages 1 and 2)
    // ------------------------------------------------------------------
    generate
        for (genvar c = 0; c < OUT_CH; c++) begin : g_ch
            xnor_popcount72 u_xp (
                .clk       (clk),
                .rst       (rst),
                .clear     (w_clear),
                .valid_in  (accept),
                .window    (pixel_windows),
                .weight    (weight[c]),
                .grp_cnt   (grp_cnt[c]),
                .valid_out (s2_valid[c])
            );
        end
    endgenerate

    // All channels advance in lockstep; AND-ing keeps every valid bit live.
    assign s2_ok = &s2_valid;

    // Unsigned compare against a 7-bit threshold: T=0 always passes and
    // T above 72 can never be reached.
    always_comb begin
        pix_next = '0;
        for (int c = 0; c < OUT_CH; c++) begin
            pix_next[c] = (sum_groups(grp_cnt[c]) >= thresh[c]);
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: threshold, output valid and frame counting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_out  <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            pix_cnt    <= '0;
        end else if (w_clear) begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            pix_cnt    <= '0;
        end else begin
            valid_out  <= s2_ok;
            frame_done <= s2_ok && (pix_cnt == PIX_W'(PIX_LAST));
            if (s2_ok) begin
                pixel_out <= pix_next;
                if (pix_cnt == PIX_W'(PIX_LAST)) begin
                    pix_cnt <= '0;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv2_xnor_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2_xnor_core
// Description : Self-checking bench for conv2_xnor_core. Stimulus pushes the
//               expected activation vector, frame flag and arrival cycle into
//               a queue; a negedge monitor pops and compares on valid_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2_xnor_core;

    localparam int NCH  = 16;
    localparam int NPIX = 121;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [71:0] pixel_windows;
    logic        w_valid;
    logic [71:0] w_data;
    logic [6:0]  w_thresh;
    logic        w_clear;
    logic        weights_ready;
    logic [15:0] pixel_out;
    logic        valid_out;
    logic        frame_done;
    logic        drop_err;

    conv2_xnor_core dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .pixel_windows (pixel_windows),
        .w_valid       (w_valid),
        .w_data        (w_data),
        .w_thresh      (w_thresh),
        .w_clear       (w_clear),
        .weights_ready (weights_ready),
        .pixel_out     (pixel_out),
        .valid_out     (valid_out),
        .frame_done    (frame_done),
        .drop_err      (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pix;
        logic        fd;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          pix_cnt_m = 0;
    logic [71:0] wm [NCH];
    int          tm [NCH];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: channel c fires when the number of agreeing bits reaches T[c].
    function automatic logic [15:0] ref_pix(input logic [71:0] win);
        logic [15:0] r;
        logic [71:0] agree;
        for (int c = 0; c < NCH; c++) begin
            agree = ~(win ^ wm[c]);
            r[c]  = ($countones(agree) >= tm[c]);
        end
        return r;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() > 0 && q[0].due < cyc) begin
                tests++;
                fails++;
                $display("FAIL missing_valid_out: required one at cycle %0d, did not arrive", q[0].due);
                void'(q.pop_front());
            end
            if (valid_out) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid_out: got pixel_out %0h at cycle %0d, required none",
                             pixel_out, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pixel_out", 64'(pixel_out), 64'(e.pix));
                    chk("frame_done", 64'(frame_done), 64'(e.fd));
                    chk("latency_cycle", 64'(cyc), 64'(e.due));
                end
            end else begin
                chk("frame_done_alone", 64'(frame_done), 64'd0);
            end
        end
    end

    task automatic drive(input logic vin, input logic [71:0] win, input logic wv,
                         input logic [71:0] wd, input logic [6:0] wt, input logic wc);
        @(posedge clk);
        #1;
        valid_in      = vin;
        pixel_windows = win;
        w_valid       = wv;
        w_data        = wd;
        w_thresh      = wt;
        w_clear       = wc;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic send(input logic [71:0] win, input bit use_lit, input logic [15:0] lit);
        exp_t e;
        drive(1'b1, win, 1'b0, '0, '0, 1'b0);
        e.pix = use_lit ? lit : ref_pix(win);
        e.fd  = (pix_cnt_m == NPIX - 1);
        e.due = cyc + 3;
        q.push_back(e);
        pix_cnt_m = (pix_cnt_m == NPIX - 1) ? 0 : pix_cnt_m + 1;
    endtask

    function automatic logic [71:0] rnd72();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[71:0];
    endfunction

    // Loads wm/tm; optionally injects a window after drop_after channels.
    task automatic load_weights(input int drop_after);
        for (int c = 0; c < NCH; c++) begin
            if (c == drop_after) begin
                drive(1'b1, rnd72(), 1'b0, '0, '0, 1'b0);
                idle();
                @(negedge clk);
                chk("drop_err_set", 64'(drop_err), 64'd1);
                chk("ready_during_load", 64'(weights_ready), 64'd0);
            end
            drive(1'b0, '0, 1'b1, wm[c], 7'(tm[c]), 1'b0);
            if (c == NCH - 1) begin
                @(negedge clk);
                chk("ready_before_last_write", 64'(weights_ready), 64'd0);
            end
        end
        idle();
        @(negedge clk);
        chk("ready_after_last_write", 64'(weights_ready), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) idle();
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d outputs outstanding, required 0", q.size());
            q.delete();
        end
        repeat (3) idle();
    endtask

    task automatic rand_weights();
        for (int c = 0; c < NCH; c++) begin
            wm[c] = rnd72();
            tm[c] = $urandom_range(30, 42);
        end
        tm[0] = 0;
        tm[1] = 73;
        tm[2] = 127;
        tm[3] = 72;
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 0; pixel_windows = '0; w_valid = 0; w_data = '0; w_thresh = '0; w_clear = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_weights_ready", 64'(weights_ready), 64'd0);
        chk("reset_pixel_out", 64'(pixel_out), 64'd0);
        chk("reset_valid_out", 64'(valid_out), 64'd0);
        chk("reset_frame_done", 64'(frame_done), 64'd0);
        chk("reset_drop_err", 64'(drop_err), 64'd0);
        rst = 1'b0;

        // Zero weights, T[c] = 4c, with a stray window after 5 channels.
        for (int c = 0; c < NCH; c++) begin
            wm[c] = '0;
            tm[c] = c * 4;
        end
        load_weights(5);
        chk("drop_err_sticky_after_load", 64'(drop_err), 64'd1);
        send(72'h0, 1'b1, 16'hFFFF);
        send(72'h0F0F_0F0F_0F0F_0F0F_0F, 1'b1, 16'h03FF);
        idle();
        drain();

        // Random weights with boundary thresholds; full frame plus one.
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
        q.delete();
        pix_cnt_m = 0;
        rand_weights();
        load_weights(7);
        for (int i = 0; i < NPIX + 1; i++) begin
            send((i == 50) ? wm[3] : rnd72(), 1'b0, '0);
        end
        idle();
        drain();
        chk("drop_err_held_in_run", 64'(drop_err), 64'd1);

        // w_clear with a window coincident and two in flight.
        send(rnd72(), 1'b0, '0);
        send(rnd72(), 1'b0, '0);
        drive(1'b1, rnd72(), 1'b0, '0, '0, 1'b1);
        q.delete();
        pix_cnt_m = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            @(negedge clk);
            chk("clear_no_valid_out", 64'(valid_out), 64'd0);
            chk("clear_weights_ready", 64'(weights_ready), 64'd0);
            chk("clear_drop_err", 64'(drop_err), 64'd0);
        end

        // Reload and stream: counter must restart from 0.
        rand_weights();
        load_weights(-1);
        for (int i = 0; i < NPIX + 4; i++) send(rnd72(), 1'b0, '0);
        idle();
        drain();

        // Asynchronous reset between clock edges mid-stream.
        for (int i = 0; i < 6; i++) send(rnd72(), 1'b0, '0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        valid_in = 1'b0;
        q.delete();
        #1;
        chk("async_rst_weights_ready", 64'(weights_ready), 64'd0);
        chk("async_rst_pixel_out", 64'(pixel_out), 64'd0);
        chk("async_rst_valid_out", 64'(valid_out), 64'd0);
        chk("async_rst_frame_done", 64'(frame_done), 64'd0);
        chk("async_rst_drop_err", 64'(drop_err), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) idle();
        @(negedge clk);
        chk("post_rst_in_load", 64'(weights_ready), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
